// File: rtl/asi_reg_arb.sv
// Round-robin arbiter sharing one single-ported register bank between the
// register-write and register-read channels; one access in flight at a time.
module asi_reg_arb #(
  parameter int AXI_SW     = 3,
  parameter int REG_AW     = 20,
  parameter int REG_DW     = 32,
  parameter int REG_WSTRBW = REG_DW/8,
  parameter int L          = $clog2(REG_DW/8),
  parameter int TIMEOUT    = 16,
  parameter int TO_W       = $clog2(TIMEOUT+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXI_SW-1:0]     s_wsize,
  input  logic [REG_AW-1:L]     s_waddr,
  input  logic [REG_DW-1:0]     s_wdata,
  input  logic [REG_WSTRBW-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic                  s_werr,
  input  logic [AXI_SW-1:0]     s_rsize,
  input  logic [REG_AW-1:L]     s_raddr,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [REG_DW-1:0]     s_rdata,
  output logic                  s_rerr,
  output logic                  m_req,
  output logic                  m_we,
  output logic [REG_AW-1:L]     m_addr,
  output logic [REG_DW-1:0]     m_wdata,
  output logic [REG_WSTRBW-1:0] m_wstrb,
  input  logic [REG_DW-1:0]     m_rdata,
  input  logic                  m_ack,
  output logic                  busy
);

  localparam int CW = (TO_W < 1) ? 1 : TO_W;

  typedef enum logic [2:0] {IDLE, WR, RD, DONE_W, DONE_R} state_t;

  state_t                r_state, w_nxt;
  logic                  r_pri_wr, r_err, r_we;
  logic [REG_AW-1:L]     r_addr;
  logic [REG_DW-1:0]     r_wdata, r_rdata;
  logic [REG_WSTRBW-1:0] r_wstrb;
  logic [CW-1:0]         r_cnt;

  logic w_gnt_wr, w_gnt_rd, w_size_ok, w_timeout;

  always_comb begin
    w_gnt_wr  = s_wvalid && (!s_rvalid || r_pri_wr);
    w_gnt_rd  = s_rvalid && !w_gnt_wr;
    w_size_ok = w_gnt_wr ? (s_wsize == AXI_SW'(L)) : (s_rsize == AXI_SW'(L));
    w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT-1));
  end

  // State register plus the datapath latched alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pri_wr <= 1'b1;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        IDLE: if (w_gnt_wr || w_gnt_rd) begin
          r_pri_wr <= w_gnt_rd;
          r_we     <= w_gnt_wr;
          r_addr   <= w_gnt_wr ? s_waddr : s_raddr;
          r_wdata  <= w_gnt_wr ? s_wdata : '0;
          r_wstrb  <= w_gnt_wr ? s_wstrb : '0;
          r_cnt    <= '0;
          r_err    <= !w_size_ok;
          if (w_gnt_rd && !w_size_ok) r_rdata <= '0;
        end
        WR, RD: begin
          if (m_ack) begin
            r_err <= 1'b0;
            if (r_state == RD) r_rdata <= m_rdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_state == RD) r_rdata <= '0;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_wr)      w_nxt = w_size_ok ? WR : DONE_W;
        else if (w_gnt_rd) w_nxt = w_size_ok ? RD : DONE_R;
      end
      WR:      if (m_ack || w_timeout) w_nxt = DONE_W;
      RD:      if (m_ack || w_timeout) w_nxt = DONE_R;
      DONE_W:  w_nxt = IDLE;
      DONE_R:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs decode flops only; nothing from s_* or m_ack reaches them directly
  always_comb begin
    m_req    = (r_state == WR) || (r_state == RD);
    m_we     = r_we;
    m_addr   = r_addr;
    m_wdata  = r_wdata;
    m_wstrb  = r_wstrb;
    s_wready = (r_state == DONE_W);
    s_rready = (r_state == DONE_R);
    s_werr   = (r_state == DONE_W) && r_err;
    s_rerr   = (r_state == DONE_R) && r_err;
    s_rdata  = r_rdata;
    busy     = (r_state != IDLE);
  end

endmodule
